// File: rtl/program_loader_if.sv
// Stream and RAM bus bundle for program_loader.
// master: upstream producer plus RAM model; slave: the loader itself.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    output in_valid, in_data, in_last, mem_rdata,
    input  in_ready, mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
  );

  modport slave (
    input  in_valid, in_data, in_last, mem_rdata,
    output in_ready, mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: streams an image into single-port RAM starting at BASE_ADDR,
// keeps a word count and additive checksum, pulses cpu_start on clean finish.
// Optional read-back verify of every word: define LOADER_VERIFY_EN.
module program_loader #(
  parameter int          ADDR_WIDTH = 28,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 'h100,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  program_loader_if.slave       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] cpu_pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef LOADER_VERIFY_EN
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_CMP    = 3'd4;
`endif

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LP_MAX  = ADDR_WIDTH'(MAX_WORDS);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_last;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_cs;
  logic                  r_mem_we;
  logic                  r_mem_oe;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_word_count;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_cpu_start;

  logic [2:0]            w_state_nxt;
  logic                  w_hs;
  logic                  w_overflow;
  logic                  w_mismatch;
  logic                  w_idle_or_done;

`ifndef LOADER_VERIFY_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus.mem_rdata;
`endif

  // Next-state decode, handshake and abort conditions
  always_comb begin
    w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    w_hs           = (r_state == S_ACCEPT) && bus.in_valid;
    w_overflow     = w_hs && (r_word_count == LP_MAX);
`ifdef LOADER_VERIFY_EN
    w_mismatch     = (r_state == S_CMP) && (bus.mem_rdata != r_hold_data);
`else
    w_mismatch     = 1'b0;
`endif
    w_state_nxt    = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_ACCEPT;
      S_ACCEPT:       if (w_hs) w_state_nxt = w_overflow ? S_DONE : S_WRITE;
`ifdef LOADER_VERIFY_EN
      S_WRITE:        w_state_nxt = S_READ;
      S_READ:         w_state_nxt = S_CMP;
      S_CMP:          w_state_nxt = (w_mismatch || r_hold_last) ? S_DONE : S_ACCEPT;
`else
      S_WRITE:        w_state_nxt = r_hold_last ? S_DONE : S_ACCEPT;
`endif
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // State, RAM strobes, counters and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hold_data  <= '0;
      r_hold_last  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_cs     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_oe     <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_checksum   <= '0;
      r_cpu_start  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
`ifdef LOADER_VERIFY_EN
      r_mem_cs    <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ) ||
                     (w_state_nxt == S_CMP);
`else
      r_mem_cs    <= (w_state_nxt == S_WRITE);
`endif
      r_mem_we    <= (w_state_nxt == S_WRITE);
      r_mem_oe    <= (w_state_nxt != S_WRITE);
      r_cpu_start <= (w_state_nxt == S_DONE) && (r_state != S_DONE) &&
                     !w_overflow && !w_mismatch;
      if (w_idle_or_done && start) begin
        r_word_count <= '0;
        r_checksum   <= '0;
        r_error      <= 1'b0;
      end
      if (w_hs) begin
        r_hold_data <= bus.in_data;
        r_hold_last <= bus.in_last;
        if (!w_overflow) r_mem_addr <= LP_BASE + r_word_count;
      end
      if (w_overflow || w_mismatch) r_error <= 1'b1;
      if (r_state == S_WRITE) begin
        r_word_count <= r_word_count + ADDR_WIDTH'(1);
        r_checksum   <= r_checksum + r_hold_data;
      end
    end
  end

  // Strobes are registered one cycle ahead, so a reset landing in the WRITE
  // cycle would still see mem_we high on its edge; gate with rst to block it.
  assign bus.mem_cs    = r_mem_cs & ~rst;
  assign bus.mem_we    = r_mem_we & ~rst;
  assign bus.mem_oe    = r_mem_oe;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_hold_data;
  assign bus.in_ready  = (r_state == S_ACCEPT);
  assign busy          = !w_idle_or_done;
  assign done          = (r_state == S_DONE);
  assign error         = r_error;
  assign word_count    = r_word_count;
  assign checksum      = r_checksum;
  assign cpu_start     = r_cpu_start;
  assign cpu_pc        = LP_BASE;

endmodule

// File: doc/program_loader.md
# program_loader

Upstream stage of the accumulator CPU. It accepts a stream of program/data words on a valid/ready port and writes them into the single-port synchronous RAM at consecutive addresses starting at `BASE_ADDR`. When the image is complete it pulses `cpu_start` so the fetch/execute control can begin at `BASE_ADDR`. It also keeps a running word count and a 32-bit additive checksum of the image.

## Interface
- `ADDR_WIDTH`, 28, RAM address width.
- `DATA_WIDTH`, 32, RAM/stream word width.
- `BASE_ADDR`, 'h100, first RAM address written; also the value driven on `cpu_pc`.
- `MAX_WORDS`, 256, image size limit in words (1..2^ADDR_WIDTH-BASE_ADDR).

Ports:
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset; has priority over every other input.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- `in_valid`  in  1  stream word present.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  DATA_WIDTH  stream word.
- `in_last`  in  1  qualifies the final word of the image.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data; the integrator tri-states it onto the RAM data bus when `mem_oe`=0.
- `mem_rdata`  in  DATA_WIDTH  RAM read data (used only with verify).
- `mem_cs`, `mem_we`, `mem_oe`  out  1 each  RAM chip select, write enable, output enable.
- `busy`  out  1  a load is in progress.
- `done`  out  1  sticky; the load has finished, with or without error.
- `error`  out  1  sticky; the load was aborted by overflow or verify mismatch.
- `word_count`  out  ADDR_WIDTH  number of words committed.
- `checksum`  out  DATA_WIDTH  sum of committed words mod 2^DATA_WIDTH.
- `cpu_start`  out  1  one-cycle pulse on successful completion.
- `cpu_pc`  out  ADDR_WIDTH  constant `BASE_ADDR`.

## Operation
- States: IDLE, ACCEPT, WRITE, READ and CMP (verify only), DONE.
- Reset values: state IDLE; `in_ready`, `mem_cs`, `mem_we`, `mem_oe`, `busy`, `done`, `error`, and `cpu_start` = 0; `mem_addr`, `mem_wdata`, `word_count`, and `checksum` = 0.
- IDLE/DONE: `start`=1 clears `word_count`, `checksum`, `done`, and `error`, then goes to ACCEPT.
- ACCEPT: `in_ready`=1 and `busy`=1. A handshake (`in_valid`&`in_ready`) captures `in_data` and `in_last` into holding registers.
  - If `word_count`==`MAX_WORDS`, the word is discarded without a write, `error`=1, and the state goes to DONE.
  - Otherwise the state goes to WRITE.
- WRITE, exactly one cycle:
  - Drives `mem_addr`=`BASE_ADDR`+`word_count`, `mem_wdata`=held word, `mem_cs`=1, `mem_we`=1, `mem_oe`=0.
  - At the end of the cycle: `word_count`+1, `checksum`+=word with wrap, no carry out.
  - Next state: READ (verify), else DONE if held last, else ACCEPT.
- DONE: `done`=1 and `busy`=0. `cpu_start` pulses for the single cycle of entry, only when `error`=0.
- Outside WRITE/READ/CMP: `mem_cs`=0, `mem_we`=0, `mem_oe`=1. The RAM data bus is never driven outside WRITE.
- `start` while busy is ignored. `in_last` outside a handshake is ignored.

## Timing
- `in_ready` deasserts for at least 1 cycle after each handshake, so peak throughput is 1 word per 2 cycles (1 per 4 with verify).
- The RAM write occurs on the posedge that ends WRITE. `word_count`/`checksum` are visible the following cycle.
- Latency from the last handshake to `done`=1 is 2 cycles (4 with verify).
- `rst` asserted in any state (including mid-WRITE) returns to reset values on that edge. No further writes occur, and memory already written is left as is.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration
- `LOADER_VERIFY_EN` defined: after WRITE, the loader reads the word back.
  - READ drives the same `mem_addr` with `mem_cs`=1, `mem_we`=0, `mem_oe`=1.
  - CMP holds those values and samples `mem_rdata` at its end (1-cycle RAM read latency).
  - On mismatch: `error`=1 and the state goes to DONE. `word_count`/`checksum` already include the word.
  - On match: the state continues to DONE or ACCEPT per the held last.
- `LOADER_VERIFY_EN` undefined: READ/CMP are not built, and `mem_rdata` is unused.

## Test plan
- Stream 'h20000113, 'h00000111, 'h10000000 (last) back-to-back -> RAM['h100..'h102] hold those words; `word_count`=3; `checksum`='h30000224; `done`=1; `error`=0; one `cpu_start` pulse; `cpu_pc`='h100.
- Same image with 3-cycle `in_valid` gaps -> identical RAM contents and checksum. `mem_we` is high in exactly 3 cycles.
- `MAX_WORDS`=4, stream 5 words with no last -> 4 writes ('h100..'h103); 5th discarded; `error`=1; `done`=1; no `cpu_start`.
- Checksum wrap: words 'hFFFFFFFF, 'h00000002 (last) -> `checksum`='h00000001.
- `rst` asserted in the WRITE cycle of word 2 -> all outputs return to reset values next cycle and no write occurs to 'h101. A new `start` then reloads from 'h100.
- With `LOADER_VERIFY_EN`, force `mem_rdata`='hDEADBEEF during CMP of word 1 -> `error`=1, `done`=1, `word_count`=1, no `cpu_start`. A `start` pulse while busy has no effect.
